// File: rtl/mmu_tlb_translate.sv
// Page-granular address translation engine.
// A software-loaded, fully-associative table is shared read-only by two
// independent translation channels (read and write).

// One translation channel: IDLE -> LOOKUP -> RESP -> IDLE.
module mmu_tlb_chan #(
  parameter  int unsigned ADDR_W     = 32,
  parameter  int unsigned PAGE_SHIFT = 20,
  parameter  int unsigned ENTRIES    = 8,
  localparam int unsigned VPN_W      = ADDR_W - PAGE_SHIFT
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic [ADDR_W-1:0]             vaddr_i,
  input  logic [7:0]                    len_i,
  input  logic [2:0]                    size_i,
  input  logic [ENTRIES-1:0]            valid_i,
  input  logic [ENTRIES-1:0]            perm_i,
  input  logic [ENTRIES-1:0][VPN_W-1:0] vpn_i,
  input  logic [ENTRIES-1:0][VPN_W-1:0] ppn_i,
  output logic [ADDR_W-1:0]             paddr_o,
  output logic                          done_o,
  output logic                          drop_o,
  output logic [15:0]                   miss_cnt_o
);

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_e;

  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   vaddr_q;
  logic [7:0]          len_q;
  logic [2:0]          size_q;
  logic                hit_q, hit_d;
  logic                perm_q, perm_d;
  logic                cross_q, cross_d;
  logic [VPN_W-1:0]    ppn_q, ppn_d;
  logic [ADDR_W:0]     span;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                done_q, done_d;
  logic                drop_q, drop_d;
  logic [15:0]         cnt_q, cnt_d;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = LOOKUP;
      LOOKUP:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture in IDLE and lookup-result registration in LOOKUP.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vaddr_q <= '0;
      len_q   <= '0;
      size_q  <= '0;
      hit_q   <= 1'b0;
      perm_q  <= 1'b0;
      cross_q <= 1'b0;
      ppn_q   <= '0;
    end else begin
      if (state_q == IDLE && start_i) begin
        vaddr_q <= vaddr_i;
        len_q   <= len_i;
        size_q  <= size_i;
      end
      if (state_q == LOOKUP) begin
        hit_q   <= hit_d;
        perm_q  <= perm_d;
        cross_q <= cross_d;
        ppn_q   <= ppn_d;
      end
    end
  end

  // Parallel compare; scanning from the top down lets the lowest index win.
  always_comb begin
    hit_d  = 1'b0;
    perm_d = 1'b0;
    ppn_d  = '0;
    for (int unsigned i = ENTRIES; i > 0; i--) begin
      if (valid_i[i-1] && vpn_i[i-1] == vaddr_q[ADDR_W-1:PAGE_SHIFT]) begin
        hit_d  = 1'b1;
        perm_d = perm_i[i-1];
        ppn_d  = ppn_i[i-1];
      end
    end
    span    = ({{(ADDR_W-7){1'b0}}, len_q} + ONE) << size_q;
    // Extra top bit of the end address flags wrap past the address space.
    cross_d = (({1'b0, vaddr_q} + span - ONE) >> PAGE_SHIFT) !=
              {{PAGE_SHIFT{1'b0}}, 1'b0, vaddr_q[ADDR_W-1:PAGE_SHIFT]};
  end

  // Output logic: response formation and saturating miss count in RESP.
  always_comb begin
    done_d  = 1'b0;
    drop_d  = 1'b0;
    paddr_d = paddr_q;
    cnt_d   = cnt_q;
    if (state_q == RESP) begin
      done_d = 1'b1;
      if (hit_q && perm_q && !cross_q) begin
        paddr_d = {ppn_q, vaddr_q[PAGE_SHIFT-1:0]};
      end else begin
        drop_d  = 1'b1;
        paddr_d = '0;
        if (cnt_q != '1) cnt_d = cnt_q + 16'd1;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      paddr_q <= '0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      paddr_q <= paddr_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
    end
  end

  assign paddr_o    = paddr_q;
  assign done_o     = done_q;
  assign drop_o     = drop_q;
  assign miss_cnt_o = cnt_q;

endmodule

module mmu_tlb_translate #(
  parameter  int unsigned ADDR_W     = 32,
  parameter  int unsigned PAGE_SHIFT = 20,
  parameter  int unsigned ENTRIES    = 8,
  localparam int unsigned IDX_W      = $clog2(ENTRIES),
  localparam int unsigned VPN_W      = ADDR_W - PAGE_SHIFT
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              rstart,
  input  logic [ADDR_W-1:0] v_raddr,
  input  logic [7:0]        r_len,
  input  logic [2:0]        r_size,
  output logic [ADDR_W-1:0] p_raddr,
  output logic              t_rdone,
  output logic              r_drop,
  input  logic              wstart,
  input  logic [ADDR_W-1:0] v_waddr,
  input  logic [7:0]        w_len,
  input  logic [2:0]        w_size,
  output logic [ADDR_W-1:0] p_waddr,
  output logic              t_wdone,
  output logic              w_drop,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [VPN_W-1:0]  cfg_vpn,
  input  logic [VPN_W-1:0]  cfg_ppn,
  input  logic              cfg_valid,
  input  logic              cfg_rperm,
  input  logic              cfg_wperm,
  output logic [15:0]       rd_miss_cnt,
  output logic [15:0]       wr_miss_cnt
);

  logic [ENTRIES-1:0]            valid_q, rperm_q, wperm_q;
  logic [ENTRIES-1:0][VPN_W-1:0] vpn_q, ppn_q;

  // Translation table; a write is seen by lookups from the next cycle.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      valid_q <= '0;
      rperm_q <= '0;
      wperm_q <= '0;
      vpn_q   <= '0;
      ppn_q   <= '0;
    end else if (cfg_we) begin
      valid_q[cfg_idx] <= cfg_valid;
      rperm_q[cfg_idx] <= cfg_rperm;
      wperm_q[cfg_idx] <= cfg_wperm;
      vpn_q[cfg_idx]   <= cfg_vpn;
      ppn_q[cfg_idx]   <= cfg_ppn;
    end
  end

  mmu_tlb_chan #(.ADDR_W(ADDR_W), .PAGE_SHIFT(PAGE_SHIFT), .ENTRIES(ENTRIES)) u_rd (
    .clk_i      (clk),
    .rst_ni     (reset_),
    .start_i    (rstart),
    .vaddr_i    (v_raddr),
    .len_i      (r_len),
    .size_i     (r_size),
    .valid_i    (valid_q),
    .perm_i     (rperm_q),
    .vpn_i      (vpn_q),
    .ppn_i      (ppn_q),
    .paddr_o    (p_raddr),
    .done_o     (t_rdone),
    .drop_o     (r_drop),
    .miss_cnt_o (rd_miss_cnt)
  );

  mmu_tlb_chan #(.ADDR_W(ADDR_W), .PAGE_SHIFT(PAGE_SHIFT), .ENTRIES(ENTRIES)) u_wr (
    .clk_i      (clk),
    .rst_ni     (reset_),
    .start_i    (wstart),
    .vaddr_i    (v_waddr),
    .len_i      (w_len),
    .size_i     (w_size),
    .valid_i    (valid_q),
    .perm_i     (wperm_q),
    .vpn_i      (vpn_q),
    .ppn_i      (ppn_q),
    .paddr_o    (p_waddr),
    .done_o     (t_wdone),
    .drop_o     (w_drop),
    .miss_cnt_o (wr_miss_cnt)
  );

endmodule

// File: tb/tb_mmu_tlb_translate.sv
// Self-checking bench for mmu_tlb_translate: directed vector table,
// hand-written timing sequences, and randomized traffic against a model.
module tb_mmu_tlb_translate;

  logic        clk = 1'b0;
  logic        reset_;
  logic        rstart, wstart;
  logic [31:0] v_raddr, v_waddr, p_raddr, p_waddr;
  logic [7:0]  r_len, w_len;
  logic [2:0]  r_size, w_size;
  logic        t_rdone, r_drop, t_wdone, w_drop;
  logic        cfg_we, cfg_valid, cfg_rperm, cfg_wperm;
  logic [2:0]  cfg_idx;
  logic [11:0] cfg_vpn, cfg_ppn;
  logic [15:0] rd_miss_cnt, wr_miss_cnt;

  always #5 clk = ~clk;

  mmu_tlb_translate #(.ADDR_W(32), .PAGE_SHIFT(20), .ENTRIES(8)) dut (
    .clk(clk), .reset_(reset_),
    .rstart(rstart), .v_raddr(v_raddr), .r_len(r_len), .r_size(r_size),
    .p_raddr(p_raddr), .t_rdone(t_rdone), .r_drop(r_drop),
    .wstart(wstart), .v_waddr(v_waddr), .w_len(w_len), .w_size(w_size),
    .p_waddr(p_waddr), .t_wdone(t_wdone), .w_drop(w_drop),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_vpn(cfg_vpn), .cfg_ppn(cfg_ppn),
    .cfg_valid(cfg_valid), .cfg_rperm(cfg_rperm), .cfg_wperm(cfg_wperm),
    .rd_miss_cnt(rd_miss_cnt), .wr_miss_cnt(wr_miss_cnt)
  );

  typedef struct {
    logic        we;  logic [2:0] idx; logic [11:0] vpn; logic [11:0] ppn;
    logic        v;   logic r;         logic w;
    logic        rs;  logic [31:0] ra; logic [7:0] rl;   logic [2:0] rsz;
    logic        ws;  logic [31:0] wa; logic [7:0] wl;   logic [2:0] wsz;
    logic [31:0] erp; logic erd;       logic [31:0] ewp; logic ewd;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Reference table and expected persistent outputs.
  logic        m_v[8], m_r[8], m_w[8];
  logic [11:0] m_vpn[8], m_ppn[8];
  logic [31:0] exp_rp = '0, exp_wp = '0;
  int          exp_rc = 0, exp_wc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int unsigned i = 0; i < 8; i++) begin
      m_v[i] = 1'b0; m_r[i] = 1'b0; m_w[i] = 1'b0; m_vpn[i] = '0; m_ppn[i] = '0;
    end
  endfunction

  function automatic void model_cfg(input vec_t t);
    if (t.we) begin
      m_v[t.idx] = t.v; m_r[t.idx] = t.r; m_w[t.idx] = t.w;
      m_vpn[t.idx] = t.vpn; m_ppn[t.idx] = t.ppn;
    end
  endfunction

  // First matching valid entry, permission, and page-span rule by arithmetic.
  function automatic void model_xlate(input logic [31:0] va, input logic [7:0] len,
                                      input logic [2:0] sz, input bit is_w,
                                      output logic [31:0] p, output logic drop);
    bit found = 1'b0;
    int unsigned sel = 0;
    longint unsigned span, last, base;
    bit ok;
    for (int unsigned i = 0; i < 8; i++)
      if (!found && m_v[i] && m_vpn[i] == va[31:20]) begin found = 1'b1; sel = i; end
    base = {32'h0, va};
    span = (longint'(len) + 1) << sz;
    last = base + span - 1;
    ok   = found && (is_w ? m_w[sel] : m_r[sel]) && ((last >> 20) == (base >> 20));
    p    = ok ? {m_ppn[sel], va[19:0]} : 32'h0;
    drop = !ok;
  endfunction

  function automatic vec_t cfg_v(input logic [2:0] idx, input logic [11:0] vpn,
                                 input logic [11:0] ppn, input logic v,
                                 input logic r, input logic w);
    vec_t t;
    t = '{we:1'b1, idx:idx, vpn:vpn, ppn:ppn, v:v, r:r, w:w,
          rs:1'b0, ra:'0, rl:'0, rsz:'0, ws:1'b0, wa:'0, wl:'0, wsz:'0,
          erp:'0, erd:1'b0, ewp:'0, ewd:1'b0};
    return t;
  endfunction

  function automatic vec_t req_v(input logic rs, input logic [31:0] ra, input logic [7:0] rl,
                                 input logic [2:0] rsz, input logic ws, input logic [31:0] wa,
                                 input logic [7:0] wl, input logic [2:0] wsz,
                                 input logic [31:0] erp, input logic erd,
                                 input logic [31:0] ewp, input logic ewd);
    vec_t t;
    t = '{we:1'b0, idx:'0, vpn:'0, ppn:'0, v:1'b0, r:1'b0, w:1'b0,
          rs:rs, ra:ra, rl:rl, rsz:rsz, ws:ws, wa:wa, wl:wl, wsz:wsz,
          erp:erp, erd:erd, ewp:ewp, ewd:ewd};
    return t;
  endfunction

  task automatic idle_inputs();
    rstart = 1'b0; wstart = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_rcnt"}, {16'h0, rd_miss_cnt}, 32'(exp_rc));
    chk({tag, "_wcnt"}, {16'h0, wr_miss_cnt}, 32'(exp_wc));
  endtask

  // Drive one cycle of config/requests, then check the response at N+2.
  task automatic run_txn(input vec_t t, input string tag);
    @(negedge clk);
    cfg_we = t.we; cfg_idx = t.idx; cfg_vpn = t.vpn; cfg_ppn = t.ppn;
    cfg_valid = t.v; cfg_rperm = t.r; cfg_wperm = t.w;
    rstart = t.rs; v_raddr = t.ra; r_len = t.rl; r_size = t.rsz;
    wstart = t.ws; v_waddr = t.wa; w_len = t.wl; w_size = t.wsz;
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    chk({tag, "_early_rdone"}, {31'h0, t_rdone}, 32'h0);
    chk({tag, "_early_wdone"}, {31'h0, t_wdone}, 32'h0);
    @(posedge clk); #1;
    if (t.rs) begin
      exp_rp = t.erp;
      if (t.erd && exp_rc < 65535) exp_rc++;
    end
    if (t.ws) begin
      exp_wp = t.ewp;
      if (t.ewd && exp_wc < 65535) exp_wc++;
    end
    chk({tag, "_rdone"}, {31'h0, t_rdone}, {31'h0, t.rs});
    chk({tag, "_rdrop"}, {31'h0, r_drop}, {31'h0, t.rs & t.erd});
    chk({tag, "_praddr"}, p_raddr, exp_rp);
    chk({tag, "_wdone"}, {31'h0, t_wdone}, {31'h0, t.ws});
    chk({tag, "_wdrop"}, {31'h0, w_drop}, {31'h0, t.ws & t.ewd});
    chk({tag, "_pwaddr"}, p_waddr, exp_wp);
    chk_counters(tag);
    @(posedge clk); #1;
    chk({tag, "_rdone_end"}, {31'h0, t_rdone}, 32'h0);
    chk({tag, "_wdone_end"}, {31'h0, t_wdone}, 32'h0);
  endtask

  function automatic logic [11:0] pick_vpn();
    int unsigned r;
    r = $urandom_range(0, 8);
    return (r == 8) ? 12'hFFF : 12'(r);
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [19:0] off;
    if ($urandom_range(0, 1) == 1) off = 20'($urandom);
    else                           off = 20'hF8000 | 20'($urandom_range(0, 32767));
    return {pick_vpn(), off};
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[14];
    vec_t t;
    int   pulses;
    logic [31:0] p;
    logic        d;

    reset_ = 1'b0;
    idle_inputs();
    cfg_idx = '0; cfg_vpn = '0; cfg_ppn = '0; cfg_valid = 1'b0; cfg_rperm = 1'b0; cfg_wperm = 1'b0;
    v_raddr = '0; r_len = '0; r_size = '0; v_waddr = '0; w_len = '0; w_size = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_praddr", p_raddr, 32'h0);
    chk("rst_pwaddr", p_waddr, 32'h0);
    chk("rst_flags", {28'h0, t_rdone, r_drop, t_wdone, w_drop}, 32'h0);
    chk_counters("rst");
    @(negedge clk);
    reset_ = 1'b1;

    tbl[0]  = cfg_v(3'd0, 12'h001, 12'h2A0, 1, 1, 1);
    tbl[1]  = req_v(1, 32'h0012_3400, 8'd3, 3'd2, 0, '0, '0, '0, 32'h2A02_3400, 0, '0, 0);
    tbl[2]  = req_v(1, 32'h001F_FFF0, 8'd7, 3'd2, 0, '0, '0, '0, 32'h0, 1, '0, 0);
    tbl[3]  = req_v(1, 32'h001F_FFF0, 8'd3, 3'd2, 0, '0, '0, '0, 32'h2A0F_FFF0, 0, '0, 0);
    tbl[4]  = req_v(0, '0, '0, '0, 1, 32'h0500_0000, 8'd0, 3'd0, '0, 0, 32'h0, 1);
    tbl[5]  = cfg_v(3'd1, 12'h010, 12'h011, 1, 1, 0);
    tbl[6]  = req_v(1, 32'h0100_0040, 8'd0, 3'd2, 1, 32'h0100_0040, 8'd0, 3'd2,
                    32'h0110_0040, 0, 32'h0, 1);
    tbl[7]  = cfg_v(3'd3, 12'hFFF, 12'h7FF, 1, 1, 1);
    tbl[8]  = req_v(0, '0, '0, '0, 1, 32'hFFFF_FFF0, 8'd3, 3'd2, '0, 0, 32'h7FFF_FFF0, 0);
    tbl[9]  = req_v(0, '0, '0, '0, 1, 32'hFFFF_FFF0, 8'd4, 3'd2, '0, 0, 32'h0, 1);
    tbl[10] = cfg_v(3'd2, 12'h003, 12'h100, 1, 1, 1);
    tbl[11] = cfg_v(3'd5, 12'h003, 12'h200, 1, 1, 1);
    tbl[12] = req_v(1, 32'h0030_0010, 8'd0, 3'd0, 0, '0, '0, '0, 32'h1000_0010, 0, '0, 0);
    tbl[13] = req_v(1, 32'h0010_0000, 8'd0, 3'd0, 0, '0, '0, '0, 32'h0, 1, '0, 0);
    tbl[13].we = 1'b1; tbl[13].idx = 3'd0; tbl[13].vpn = 12'h001; tbl[13].ppn = 12'h2A0;
    tbl[13].v = 1'b0;  tbl[13].r = 1'b1;   tbl[13].w = 1'b1;

    for (int unsigned i = 0; i < 14; i++) begin
      model_cfg(tbl[i]);
      run_txn(tbl[i], $sformatf("vec%0d", i));
    end

    // Config write during LOOKUP must not affect the in-flight lookup.
    t = cfg_v(3'd0, 12'h001, 12'h2A0, 1, 1, 1);
    model_cfg(t);
    run_txn(t, "restore_e0");
    @(negedge clk);
    rstart = 1'b1; v_raddr = 32'h0010_0000; r_len = 8'd0; r_size = 3'd0;
    @(posedge clk); #1;
    rstart = 1'b0;
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 3'd0; cfg_valid = 1'b0; cfg_vpn = 12'h001; cfg_ppn = 12'h2A0;
    m_v[0] = 1'b0;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    @(posedge clk); #1;
    exp_rp = 32'h2A00_0000;
    chk("lkcfg_rdone", {31'h0, t_rdone}, 32'h1);
    chk("lkcfg_rdrop", {31'h0, r_drop}, 32'h0);
    chk("lkcfg_praddr", p_raddr, exp_rp);
    run_txn(req_v(1, 32'h0010_0000, 8'd0, 3'd0, 0, '0, '0, '0, 32'h0, 1, '0, 0), "lkcfg_after");

    // Second start while busy is ignored; one response with the lowest-index hit.
    @(negedge clk);
    rstart = 1'b1; v_raddr = 32'h0030_0010; r_len = 8'd0; r_size = 3'd0;
    @(posedge clk); #1;
    rstart = 1'b0;
    @(negedge clk);
    rstart = 1'b1; v_raddr = 32'h0030_0020;
    @(posedge clk); #1;
    rstart = 1'b0;
    pulses = 0;
    for (int unsigned k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (t_rdone) pulses++;
    end
    exp_rp = 32'h1000_0010;
    chk("busy_pulses", 32'(pulses), 32'h1);
    chk("busy_praddr", p_raddr, exp_rp);

    // Reset during LOOKUP: no response, everything cleared, start accepted at once.
    @(negedge clk);
    rstart = 1'b1; v_raddr = 32'h0030_0000; r_len = 8'd0; r_size = 3'd0;
    @(posedge clk); #1;
    rstart = 1'b0;
    @(negedge clk);
    reset_ = 1'b0;
    #1;
    model_clear();
    exp_rp = '0; exp_wp = '0; exp_rc = 0; exp_wc = 0;
    chk("midrst_praddr", p_raddr, 32'h0);
    chk("midrst_pwaddr", p_waddr, 32'h0);
    chk_counters("midrst");
    for (int unsigned k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk($sformatf("midrst_flags%0d", k), {28'h0, t_rdone, r_drop, t_wdone, w_drop}, 32'h0);
    end
    @(negedge clk);
    reset_ = 1'b1;
    rstart = 1'b1; v_raddr = 32'h0030_0000;
    @(posedge clk); #1;
    rstart = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    exp_rc = 1;
    chk("postrst_rdone", {31'h0, t_rdone}, 32'h1);
    chk("postrst_rdrop", {31'h0, r_drop}, 32'h1);
    chk("postrst_praddr", p_raddr, 32'h0);
    chk_counters("postrst");
    @(posedge clk); #1;

    // Randomized traffic checked against the reference model.
    for (int unsigned n = 0; n < 400; n++) begin
      t = req_v(1'($urandom_range(0, 1)), rand_addr(), 8'($urandom), 3'($urandom),
                1'($urandom_range(0, 1)), rand_addr(), 8'($urandom), 3'($urandom),
                '0, 0, '0, 0);
      t.we  = 1'($urandom_range(0, 1));
      t.idx = 3'($urandom_range(0, 7));
      t.vpn = pick_vpn();
      t.ppn = 12'($urandom);
      t.v   = ($urandom_range(0, 3) != 0);
      t.r   = 1'($urandom_range(0, 1));
      t.w   = 1'($urandom_range(0, 1));
      model_cfg(t);
      model_xlate(t.ra, t.rl, t.rsz, 1'b0, p, d);
      t.erp = p; t.erd = d;
      model_xlate(t.wa, t.wl, t.wsz, 1'b1, p, d);
      t.ewp = p; t.ewd = d;
      run_txn(t, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
